// File: rtl/cud_seq.sv
// Command-driven sequencer for an up/down counter: loads a start value and direction,
// lets the counter run for a programmed number of rollovers, then reports completion.
module cud_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAPW  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_load,
    input  logic             cmd_ud,
    input  logic [LAPW-1:0]  cmd_laps,
    input  logic             cmd_pingpong,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LAPW-1:0]  laps_done,
    output logic             cnt_load_en,
    output logic [WIDTH-1:0] cnt_load,
    output logic             cnt_ud,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_rollover
);

    localparam logic [LAPW-1:0] LAPS_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] load;
        logic [LAPW-1:0]  laps;
        logic             pingpong;
    } cmd_t;

    state_t          state_q;
    state_t          state_d;
    cmd_t            cmd_q;
    logic [LAPW-1:0] laps_done_q;
    logic            aborted_q;
    logic            cnt_ud_q;

    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            load_en_q;

    logic            accept;
    logic            lap_hit;
    logic            abort_live;
    logic            final_lap;
    logic [LAPW-1:0] laps_inc;

    // Qualified events; rollovers and aborts only matter while a command is active
    assign accept     = cmd_valid && (state_q == S_IDLE);
    assign lap_hit    = cnt_rollover && (state_q == S_RUN);
    assign abort_live = abort && ((state_q == S_LOAD) || (state_q == S_RUN));
    assign laps_inc   = (laps_done_q == LAPS_MAX) ? laps_done_q : LAPW'(laps_done_q + 1'b1);
    assign final_lap  = lap_hit && (laps_inc == cmd_q.laps);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a same-cycle final rollover
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort || (cmd_q.laps == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || final_lap) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status and counter-control flags, decoded from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_en_q <= 1'b1;
        end else begin
            ready_q   <= (state_d == S_IDLE);
            busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            load_en_q <= (state_d != S_RUN);
        end
    end

    // Command capture, lap counting and direction control
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q       <= '0;
            laps_done_q <= '0;
            aborted_q   <= 1'b0;
            cnt_ud_q    <= 1'b1;
        end else begin
            if (accept) begin
                cmd_q.load     <= cmd_load;
                cmd_q.laps     <= cmd_laps;
                cmd_q.pingpong <= cmd_pingpong;
                laps_done_q    <= '0;
                aborted_q      <= 1'b0;
                cnt_ud_q       <= cmd_ud;
            end
            if (lap_hit) begin
                laps_done_q <= laps_inc;
                if (cmd_q.pingpong) begin
                    cnt_ud_q <= ~cnt_ud_q;
                end
            end
            if (abort_live) begin
                aborted_q <= 1'b1;
            end
        end
    end

    // Output decode; outside LOAD the counter is held by reloading its own value
    always_comb begin
        cmd_ready   = ready_q;
        busy        = busy_q;
        done        = done_q;
        aborted     = aborted_q;
        laps_done   = laps_done_q;
        cnt_load_en = load_en_q;
        cnt_ud      = cnt_ud_q;
        cnt_load    = cnt_count;
        if (state_q == S_LOAD) begin
            cnt_load = cmd_q.load;
        end
    end

endmodule

// File: tb/tb_cud_seq.sv
// Bench for cud_seq: directed commands against a behavioural up/down counter, with a
// scoreboard queue of expected completions checked by an independent monitor.
module tb_cud_seq;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned LAPW  = 8;

    logic             clk;
    logic             rstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_load;
    logic             cmd_ud;
    logic [LAPW-1:0]  cmd_laps;
    logic             cmd_pingpong;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [LAPW-1:0]  laps_done;
    logic             cnt_load_en;
    logic [WIDTH-1:0] cnt_load;
    logic             cnt_ud;
    logic [WIDTH-1:0] cnt_count;
    logic             cnt_rollover;

    cud_seq #(.WIDTH(WIDTH), .LAPW(LAPW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_load     (cmd_load),
        .cmd_ud       (cmd_ud),
        .cmd_laps     (cmd_laps),
        .cmd_pingpong (cmd_pingpong),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .laps_done    (laps_done),
        .cnt_load_en  (cnt_load_en),
        .cnt_load     (cnt_load),
        .cnt_ud       (cnt_ud),
        .cnt_count    (cnt_count),
        .cnt_rollover (cnt_rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter: rollover pulses in the cycle the wrapped value is shown
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_count    <= '0;
            cnt_rollover <= 1'b0;
        end else if (cnt_load_en) begin
            cnt_count    <= cnt_load;
            cnt_rollover <= 1'b0;
        end else if (cnt_ud) begin
            cnt_count    <= WIDTH'(cnt_count + 1'b1);
            cnt_rollover <= (cnt_count == {WIDTH{1'b1}});
        end else begin
            cnt_count    <= WIDTH'(cnt_count - 1'b1);
            cnt_rollover <= (cnt_count == '0);
        end
    end

    typedef struct {
        int          lat;
        logic        ab;
        logic [7:0]  laps;
        logic [3:0]  cnt;
        logic        ud;
        int          tog;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic ab, input logic [7:0] laps,
                                input logic [3:0] cnt, input logic ud, input int tog);
        exp_t e;
        e.lat  = lat;
        e.ab   = ab;
        e.laps = laps;
        e.cnt  = cnt;
        e.ud   = ud;
        e.tog  = tog;
        return e;
    endfunction

    // Monitor: tracks each accepted command and scores it when done pulses
    int         cyc = 0;
    int         start_cyc = 0;
    int         tog = 0;
    bit         inflight = 0;
    bit         first = 0;
    logic       prev_ud;
    bit         hold_chk = 0;
    logic [3:0] held_cnt;
    exp_t       em;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            inflight = 0;
            hold_chk = 0;
        end else begin
            if (inflight) begin
                if (first) begin
                    prev_ud = cnt_ud;
                    first   = 0;
                end else begin
                    if (cnt_ud !== prev_ud) tog++;
                    prev_ud = cnt_ud;
                end
            end
            if (hold_chk) begin
                check("hold_count", 32'(cnt_count), 32'(held_cnt));
                check("ready_after_done", 32'(cmd_ready), 32'd1);
                check("laps_held", 32'(laps_done), 32'(em.laps));
                check("aborted_held", 32'(aborted), 32'(em.ab));
                hold_chk = 0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    em = q.pop_front();
                    check("done_latency", 32'(cyc - start_cyc), 32'(em.lat));
                    check("aborted", 32'(aborted), 32'(em.ab));
                    check("laps_done", 32'(laps_done), 32'(em.laps));
                    check("count_at_done", 32'(cnt_count), 32'(em.cnt));
                    check("ud_at_done", 32'(cnt_ud), 32'(em.ud));
                    check("ud_toggles", 32'(tog), 32'(em.tog));
                    check("ready_low_in_done", 32'(cmd_ready), 32'd0);
                    held_cnt = cnt_count;
                    hold_chk = 1;
                end
                inflight = 0;
            end
            if (cmd_valid && cmd_ready) begin
                inflight  = 1;
                first     = 1;
                tog       = 0;
                start_cyc = cyc;
            end
        end
    end

    task automatic issue(input logic [3:0] ld, input logic ud, input logic [7:0] lp,
                         input logic pp, input bit expect_done, input exp_t e);
        bit got;
        if (expect_done) q.push_back(e);
        @(posedge clk);
        #1;
        cmd_load     = ld;
        cmd_ud       = ud;
        cmd_laps     = lp;
        cmd_pingpong = pp;
        cmd_valid    = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_aborted"}, 32'(aborted), 32'd0);
        check({tag, "_laps"}, 32'(laps_done), 32'd0);
        check({tag, "_ud"}, 32'(cnt_ud), 32'd1);
        check({tag, "_load_en"}, 32'(cnt_load_en), 32'd1);
    endtask

    exp_t none;

    initial begin
        none         = mk(0, 1'b0, 8'd0, 4'd0, 1'b0, 0);
        rstn         = 1'b0;
        cmd_valid    = 1'b0;
        cmd_load     = '0;
        cmd_ud       = 1'b0;
        cmd_laps     = '0;
        cmd_pingpong = 1'b0;
        abort        = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Idle with no command: counter frozen, no done
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(cmd_ready), 32'd1);
            check("idle_load_en", 32'(cnt_load_en), 32'd1);
            check("idle_count", 32'(cnt_count), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        // Single up lap from 14: 15, 0(rollover), done, frozen at 1
        issue(4'd14, 1'b1, 8'd1, 1'b0, 1, mk(5, 1'b0, 8'd1, 4'd1, 1'b1, 0));
        wait_done();

        // Ping-pong from 1 down, three laps
        issue(4'd1, 1'b0, 8'd3, 1'b1, 1, mk(11, 1'b0, 8'd3, 4'd14, 1'b1, 3));
        wait_done();

        // Load only
        issue(4'd9, 1'b0, 8'd0, 1'b0, 1, mk(2, 1'b0, 8'd0, 4'd9, 1'b0, 0));
        wait_done();

        // Abort after first of four laps
        issue(4'd15, 1'b1, 8'd4, 1'b0, 1, mk(5, 1'b1, 8'd1, 4'd2, 1'b1, 0));
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done();

        // Reset in the middle of a run drops the command
        issue(4'd3, 1'b1, 8'd5, 1'b0, 0, none);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1 check_reset_vals("midrun_reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Fresh command after reset
        issue(4'd14, 1'b1, 8'd1, 1'b0, 1, mk(5, 1'b0, 8'd1, 4'd1, 1'b1, 0));
        wait_done();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
